sme_rng_bank: RTL and testbench
===============================

// Module: sme_rng_bank
// PURPOSE
//  Generates the RMAX random XLEN-bit guard words consumed each cycle by the SME
//  masked datapath (rng[RM:0] of the AES/logic crypto unit and its masked S-box).
//  Holds one xorshift32 generator per lane, seeded word-by-word over a
//  valid/ready port from the entropy source, and advanced on demand.
//  Flags stale entropy through a step-count reseed request.
// PARAMETERS
//  XLEN        32       datapath word width; must be 32 (xorshift32 lanes)
//  SMAX        3        max hardware shares; RMAX = SMAX+SMAX*(SMAX-1)/2 lanes (6)
//  RESEED_CNT  16'hFFFF steps after which reseed_req is raised
// PORTS
//  g_clk       in   1          global clock
//  g_resetn    in   1          synchronous active-low reset
//  seed_valid  in   1          seed word offered
//  seed_ready  out  1          seed word accepted when seed_valid && seed_ready
//  seed_data   in   XLEN       seed word for lane seed_idx
//  reseed      in   1          pulse: discard state, restart seeding at lane 0
//  step        in   1          advance all lanes one xorshift step (RUN only)
//  rng         out  XLEN x RMAX  lane states, registered (rng[i] = lane i)
//  rng_ok      out  1          all lanes seeded since last reset/reseed
//  reseed_req  out  1          step count reached RESEED_CNT; sticky
// BEHAVIOUR
//  Reset (g_resetn=0 at posedge): state=LOAD, seed_idx=0, rng[i]=i+1,
//   step_cnt=0, rng_ok=0, reseed_req=0. seed_ready is combinational: 1 in LOAD.
//  States: LOAD, RUN.
//   LOAD: seed_ready=1. On accept: lane[seed_idx] <= (seed_data==0 ? 32'h1 :
//    seed_data); seed_idx++. Accept at seed_idx==RM -> RUN, rng_ok<=1,
//    seed_idx<=0, step_cnt<=0, reseed_req<=0. step ignored in LOAD.
//   RUN: seed_ready=0, seed_valid ignored. step=1 -> every lane x updated
//    next cycle: x^=x<<13; x^=x>>17; x^=x<<5 (all 32-bit, bits shifted out lost).
//    step=0 -> lanes hold (same random words re-presented; consumer must step
//    per use). step_cnt increments per step, saturating at RESEED_CNT;
//    reseed_req<=1 when step_cnt reaches RESEED_CNT. Stepping continues.
//  reseed=1 in any state: next cycle state=LOAD, seed_idx=0, rng_ok=0,
//   step_cnt=0, reseed_req=0; lane values hold until overwritten by new seeds.
//   reseed has priority over step and over a same-cycle seed accept.
//  Lanes never reach zero: seeds forced nonzero, xorshift32 is a bijection on
//   nonzero words.
//  Latency: seed accept -> lane visible on rng next cycle; step -> new words
//   next cycle. rng_ok rises the cycle after the RMAX-th accept.
//  Partial seeding (reseed or reset before RMAX words): rng_ok stays 0;
//   already-written lanes keep new seeds, others keep old values.
// TESTING
//  1 Reset, offer seeds 1..6 back-to-back -> seed_ready 1 for 6 cycles then 0;
//    rng_ok=1; rng[0..5]=1..6.
//  2 After (1), step one cycle -> rng[0]=32'h00042021; step held 0 for 3 cycles
//    -> rng unchanged.
//  3 Seed word 0 for lane 2 -> rng[2]=32'h1 after seeding completes.
//  4 reseed after 3 accepted seeds with seed_valid=1 same cycle -> word not
//    taken, seed_idx=0, rng_ok=0; 6 further seeds needed before rng_ok=1.
//  5 RESEED_CNT=4: 4 steps -> reseed_req=1 after 4th; steps continue, flag
//    sticky; reseed clears it.
//  6 step and reseed same cycle in RUN -> lanes not advanced, state LOAD.

Source files
------------

// File: rtl/sme_rng_bank.sv
// rtl/sme_rng_bank.sv - bank of seedable xorshift32 lanes supplying masking guard words
// Lanes are loaded word-by-word in LOAD, then advanced together on step in RUN.
module sme_rng_bank #(
    parameter int          XLEN       = 32,
    parameter int          SMAX       = 3,
    parameter logic [15:0] RESEED_CNT = 16'hFFFF,
    localparam int         RMAX       = SMAX + SMAX * (SMAX - 1) / 2,
    localparam int         RM         = RMAX - 1,
    localparam int         IW         = (RMAX > 1) ? $clog2(RMAX) : 1
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    input  logic                       seed_valid,
    output logic                       seed_ready,
    input  logic [XLEN-1:0]            seed_data,
    input  logic                       reseed,
    input  logic                       step,
    output logic [RMAX-1:0][XLEN-1:0]  rng,
    output logic                       rng_ok,
    output logic                       reseed_req
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   seed_idx;
    logic [15:0]     step_cnt;
    logic            accept;
    logic            last_lane;

    function automatic logic [XLEN-1:0] xorshift32(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // A reseed in the same cycle as an offered word wins: the word is not taken.
    assign accept    = seed_valid && seed_ready && !reseed;
    assign last_lane = (seed_idx == IW'(RM));

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        seed_ready = 1'b0;
        case (state)
            ST_LOAD: begin
                seed_ready = 1'b1;
                if (accept && last_lane) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                seed_ready = 1'b0;
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
        if (reseed) begin
            state_nxt = ST_LOAD;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            seed_idx   <= '0;
            step_cnt   <= '0;
            rng_ok     <= 1'b0;
            reseed_req <= 1'b0;
            for (int i = 0; i < RMAX; i++) begin
                rng[i] <= XLEN'(i + 1);
            end
        end else if (reseed) begin
            // Lane contents are kept; only the bookkeeping restarts.
            seed_idx   <= '0;
            step_cnt   <= '0;
            rng_ok     <= 1'b0;
            reseed_req <= 1'b0;
        end else if (state == ST_LOAD) begin
            if (accept) begin
                rng[seed_idx] <= (seed_data == '0) ? XLEN'(1) : seed_data;
                if (last_lane) begin
                    seed_idx   <= '0;
                    step_cnt   <= '0;
                    rng_ok     <= 1'b1;
                    reseed_req <= 1'b0;
                end else begin
                    seed_idx <= seed_idx + IW'(1);
                end
            end
        end else if (step) begin
            for (int i = 0; i < RMAX; i++) begin
                rng[i] <= xorshift32(rng[i]);
            end
            // Count saturates; the request flag stays up until reseed/reset.
            if (step_cnt != RESEED_CNT) begin
                step_cnt <= step_cnt + 16'd1;
                if (step_cnt + 16'd1 == RESEED_CNT) begin
                    reseed_req <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sme_rng_bank.sv
// tb/tb_sme_rng_bank.sv - directed and randomized checks of sme_rng_bank against a lane model
module tb_sme_rng_bank;

    localparam int          RMAX = 6;
    localparam logic [15:0] RC   = 16'd4;

    logic                     g_clk = 1'b0;
    logic                     g_resetn;
    logic                     seed_valid;
    logic                     seed_ready;
    logic [31:0]              seed_data;
    logic                     reseed;
    logic                     step;
    logic [RMAX-1:0][31:0]    rng;
    logic                     rng_ok;
    logic                     reseed_req;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_lane [RMAX];
    bit          m_run;
    bit          m_ok;
    bit          m_req;
    int          m_idx;
    int          m_steps;
    logic [31:0] saved [RMAX];

    always #5 g_clk = ~g_clk;

    sme_rng_bank #(
        .XLEN(32),
        .SMAX(3),
        .RESEED_CNT(RC)
    ) dut (
        .g_clk(g_clk),
        .g_resetn(g_resetn),
        .seed_valid(seed_valid),
        .seed_ready(seed_ready),
        .seed_data(seed_data),
        .reseed(reseed),
        .step(step),
        .rng(rng),
        .rng_ok(rng_ok),
        .reseed_req(reseed_req)
    );

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] a;
        a = x ^ (x << 13);
        a = a ^ (a >> 17);
        a = a ^ (a << 5);
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!g_resetn) begin
            m_run = 0; m_ok = 0; m_req = 0; m_idx = 0; m_steps = 0;
            for (int i = 0; i < RMAX; i++) m_lane[i] = 32'(i + 1);
        end else if (reseed) begin
            m_run = 0; m_ok = 0; m_req = 0; m_idx = 0; m_steps = 0;
        end else if (!m_run) begin
            if (seed_valid) begin
                m_lane[m_idx] = (seed_data == 0) ? 32'h1 : seed_data;
                m_idx++;
                if (m_idx == RMAX) begin
                    m_run = 1; m_ok = 1; m_req = 0; m_idx = 0; m_steps = 0;
                end
            end
        end else if (step) begin
            for (int i = 0; i < RMAX; i++) m_lane[i] = xs(m_lane[i]);
            m_steps++;
            if (m_steps >= int'(RC)) m_req = 1;
        end
    endtask

    task automatic tick();
        chk("seed_ready", 32'(seed_ready), 32'(!m_run));
        @(posedge g_clk);
        model_edge();
        #1;
        for (int i = 0; i < RMAX; i++) chk($sformatf("rng[%0d]", i), rng[i], m_lane[i]);
        chk("rng_ok", 32'(rng_ok), 32'(m_ok));
        chk("reseed_req", 32'(reseed_req), 32'(m_req));
    endtask

    task automatic seed_words(input int n);
        seed_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            seed_data = $urandom;
            tick();
        end
        seed_valid = 1'b0;
    endtask

    initial begin
        g_resetn = 1'b0; seed_valid = 1'b0; seed_data = '0; reseed = 1'b0; step = 1'b0;
        #1;
        tick();
        tick();
        g_resetn = 1'b1;

        // Seeds 1..6 back-to-back
        seed_valid = 1'b1;
        for (int i = 0; i < RMAX; i++) begin
            chk("t1_ready_load", 32'(seed_ready), 32'h1);
            seed_data = 32'(i + 1);
            tick();
        end
        seed_valid = 1'b0;
        chk("t1_ready_run", 32'(seed_ready), 32'h0);
        chk("t1_ok", 32'(rng_ok), 32'h1);
        chk("t1_lane0", rng[0], 32'h1);
        chk("t1_lane5", rng[5], 32'h6);

        // One step, then hold
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("t2_step", rng[0], 32'h00042021);
        tick(); tick(); tick();
        chk("t2_hold", rng[0], 32'h00042021);

        // Reseed after 3 accepts; competing seed word must be dropped
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
        seed_words(3);
        saved[3] = rng[3];
        reseed = 1'b1; seed_valid = 1'b1; seed_data = 32'hDEADBEEF;
        tick();
        reseed = 1'b0; seed_valid = 1'b0;
        chk("t4_notaken", rng[3], saved[3]);
        chk("t4_ok", 32'(rng_ok), 32'h0);

        // Full reseed with a zero word for lane 2
        seed_valid = 1'b1;
        for (int i = 0; i < RMAX; i++) begin
            seed_data = (i == 2) ? 32'h0 : $urandom;
            if (i == 0) chk("t4_idx0_lane0_pre", 32'(rng_ok), 32'h0);
            tick();
            if (i == RMAX - 2) chk("t4_ok_5", 32'(rng_ok), 32'h0);
        end
        seed_valid = 1'b0;
        chk("t4_ok_6", 32'(rng_ok), 32'h1);
        chk("t3_zero_seed", rng[2], 32'h1);

        // Step count threshold, sticky flag
        step = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_req_3", 32'(reseed_req), 32'h0);
        tick();
        chk("t5_req_4", 32'(reseed_req), 32'h1);
        tick(); tick();
        chk("t5_sticky", 32'(reseed_req), 32'h1);
        step = 1'b0;
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
        chk("t5_clear", 32'(reseed_req), 32'h0);

        // step + reseed together in RUN
        seed_words(RMAX);
        for (int i = 0; i < RMAX; i++) saved[i] = rng[i];
        step = 1'b1; reseed = 1'b1;
        tick();
        step = 1'b0; reseed = 1'b0;
        chk("t6_no_adv", rng[4], saved[4]);
        chk("t6_load", 32'(seed_ready), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            seed_valid = ($urandom_range(0, 3) != 0);
            seed_data  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            step       = ($urandom_range(0, 1) == 1);
            reseed     = ($urandom_range(0, 40) == 0);
            g_resetn   = (n != 200);
            tick();
        end
        g_resetn = 1'b1; seed_valid = 1'b0; step = 1'b0; reseed = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
